// File: rtl/ibex_pmp_seq_checker.sv
// ibex_pmp_seq_checker: sequential multi-channel PMP checker; one shared match engine scans
// RegionsPerCycle regions per cycle, requests are served round-robin over valid/ready.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   csr_pmp_cfg_i          per-region {lock, mode[1:0], exec, write, read}
//                          mode: 0 OFF, 1 TOR, 2 NA4, 3 NAPOT
//   csr_pmp_addr_i         per-region byte address ({pmpaddr, 2'b00})
//   csr_pmp_mseccfg_i      {rlb, mmwp, mml}
//   csr_pmp_update_i       pulse on any PMP CSR write; restarts an active scan
//   req_valid_i/ready_o    per-channel request handshake (ready one-hot or zero)
//   req_addr/type/priv_i   request address, type (0 EXEC, 1 WRITE, 2 READ), privilege (0 U, 1 S, 3 M)
//   rsp_valid_o/ready_i    per-channel response handshake (valid one-hot or zero)
//   rsp_err_o, rsp_region_o  fault flag and lowest matching region (PMPNumRegions if none)
module ibex_pmp_seq_checker #(
    parameter int PMPGranularity  = 0,
    parameter int PMPNumChan      = 2,
    parameter int PMPNumRegions   = 16,
    parameter int RegionsPerCycle = 4,
    parameter int AddrWidth       = 34
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [PMPNumRegions-1:0][5:0]            csr_pmp_cfg_i,
    input  logic [PMPNumRegions-1:0][AddrWidth-1:0]  csr_pmp_addr_i,
    input  logic [2:0]                               csr_pmp_mseccfg_i,
    input  logic                                     csr_pmp_update_i,
    input  logic [PMPNumChan-1:0]                    req_valid_i,
    output logic [PMPNumChan-1:0]                    req_ready_o,
    input  logic [PMPNumChan-1:0][AddrWidth-1:0]     req_addr_i,
    input  logic [PMPNumChan-1:0][1:0]               req_type_i,
    input  logic [PMPNumChan-1:0][1:0]               req_priv_i,
    output logic [PMPNumChan-1:0]                    rsp_valid_o,
    input  logic [PMPNumChan-1:0]                    rsp_ready_i,
    output logic                                     rsp_err_o,
    output logic [$clog2(PMPNumRegions+1)-1:0]       rsp_region_o
);
    localparam int Lsb       = PMPGranularity + 2;
    localparam int NumGroups = PMPNumRegions / RegionsPerCycle;
    localparam int GW        = NumGroups > 1 ? $clog2(NumGroups) : 1;
    localparam int CW        = PMPNumChan > 1 ? $clog2(PMPNumChan) : 1;
    localparam int RW        = $clog2(PMPNumRegions + 1);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

    state_e                               r_state, w_state_n;
    logic [CW-1:0]                        r_rr, r_chan, w_gidx;
    logic [AddrWidth-1:0]                 r_addr;
    logic [1:0]                           r_type, r_priv;
    logic [GW-1:0]                        r_group;
    logic                                 r_err;
    logic [RW-1:0]                        r_region, w_hit_idx;
    logic                                 w_any, w_hit, w_hit_err, w_last;
    logic [PMPNumRegions:0][AddrWidth-1:0] w_prev;
    logic                                 w_unused;

    // TOR lower bound: entry k holds region k-1's address, entry 0 is zero
    assign w_prev   = {csr_pmp_addr_i, {AddrWidth{1'b0}}};
    assign w_unused = ^{csr_pmp_mseccfg_i[2], w_prev[PMPNumRegions]};

    function automatic logic f_match(input logic [1:0] mode, input logic [AddrWidth-1:0] a,
                                     input logic [AddrWidth-1:0] ra, input logic [AddrWidth-1:0] pa);
        logic [AddrWidth-1:0] care;
        logic                 ones;
        care = '0;
        ones = 1'b1;
        // NAPOT: a bit is don't-care while every pmpaddr bit below it (from bit 2) is one
        for (int b = 2; b < AddrWidth; b++) begin
            care[b] = (b >= Lsb) && (mode == 2'b10 || !ones);
            ones    = ones & ra[b];
        end
        return mode == 2'b01 ? (a[AddrWidth-1:Lsb] >= pa[AddrWidth-1:Lsb] &&
                                a[AddrWidth-1:Lsb] <  ra[AddrWidth-1:Lsb]) :
               mode[1]       ? ((a ^ ra) & care) == '0 : 1'b0;
    endfunction

    function automatic logic f_err(input logic [5:0] cfg, input logic [1:0] t,
                                   input logic [1:0] p, input logic mml);
        logic m, rd, wr, ex, l, perm;
        m    = p == 2'b11;
        rd   = t == 2'b10;
        wr   = t == 2'b01;
        ex   = t == 2'b00;
        l    = cfg[5];
        perm = (rd & cfg[0]) | (wr & cfg[1]) | (ex & cfg[2]);
        if (!mml)
            return (m ? l : 1'b1) & ~perm;
        // MML shared-region encodings (R=0, W=1) selected by {L, X}
        if (!cfg[0] && cfg[1])
            return ~({l, cfg[2]} == 2'b00 ? rd | (wr & m) :
                     {l, cfg[2]} == 2'b01 ? rd | wr :
                     {l, cfg[2]} == 2'b10 ? ex : ex | (rd & m));
        return ~perm | (m ? ~l : l);
    endfunction

    // Scan the current group; descending loop leaves the lowest matching index
    always_comb begin
        w_hit     = 1'b0;
        w_hit_err = 1'b0;
        w_hit_idx = RW'(PMPNumRegions);
        for (int j = RegionsPerCycle - 1; j >= 0; j--) begin
            if (f_match(csr_pmp_cfg_i[int'(r_group) * RegionsPerCycle + j][4:3], r_addr,
                        csr_pmp_addr_i[int'(r_group) * RegionsPerCycle + j],
                        w_prev[int'(r_group) * RegionsPerCycle + j])) begin
                w_hit     = 1'b1;
                w_hit_idx = RW'(int'(r_group) * RegionsPerCycle + j);
                w_hit_err = f_err(csr_pmp_cfg_i[int'(r_group) * RegionsPerCycle + j],
                                  r_type, r_priv, csr_pmp_mseccfg_i[0]);
            end
        end
    end

    // Round-robin grant starting after the last granted channel, plus FSM next state
    always_comb begin
        w_any  = 1'b0;
        w_gidx = r_rr;
        for (int i = PMPNumChan; i >= 1; i--) begin
            if (req_valid_i[(int'(r_rr) + i) % PMPNumChan]) begin
                w_any  = 1'b1;
                w_gidx = CW'((int'(r_rr) + i) % PMPNumChan);
            end
        end
        w_last              = int'(r_group) == NumGroups - 1;
        req_ready_o         = '0;
        req_ready_o[w_gidx] = r_state == IDLE && w_any && !rst_i;
        rsp_valid_o         = '0;
        rsp_valid_o[r_chan] = r_state == RESP;
        w_state_n = r_state == IDLE ? (w_any ? SCAN : IDLE) :
                    r_state == SCAN ? (!csr_pmp_update_i && (w_hit || w_last) ? RESP : SCAN) :
                    r_state == RESP ? (rsp_ready_i[r_chan] ? IDLE : RESP) : IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_state <= IDLE;
        else
            r_state <= w_state_n;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr     <= CW'(PMPNumChan - 1);
            r_chan   <= '0;
            r_addr   <= '0;
            r_type   <= '0;
            r_priv   <= '0;
            r_group  <= '0;
            r_err    <= 1'b0;
            r_region <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_addr  <= req_addr_i[w_gidx];
                r_type  <= req_type_i[w_gidx];
                r_priv  <= req_priv_i[w_gidx];
                r_chan  <= w_gidx;
                r_rr    <= w_gidx;
                r_group <= '0;
            end
            if (r_state == SCAN) begin
                // a CSR write mid-scan discards this cycle and restarts from group 0
                r_group <= csr_pmp_update_i ? '0 : r_group + GW'(1);
                if (!csr_pmp_update_i && (w_hit || w_last)) begin
                    r_err    <= w_hit ? w_hit_err : csr_pmp_mseccfg_i[1] | (r_priv != 2'b11);
                    r_region <= w_hit_idx;
                end
            end
        end
    end

    assign rsp_err_o    = r_err;
    assign rsp_region_o = r_region;
endmodule
